// File: rtl/flagreg_pkg.sv
// Shared constants and op encoding for the flag register with interrupt save stack.
package flagreg_pkg;

   localparam int FLAG_C     = 0;
   localparam int FLAG_Z     = 1;
   localparam int NFLAGS_DEF = 2;

   typedef enum logic [1:0] {
      OP_NONE  = 2'd0,
      OP_WRITE = 2'd1,
      OP_PUSH  = 2'd2,
      OP_POP   = 2'd3
   } flag_op_e;

endpackage

// File: rtl/flag_lifo.sv
// LIFO of saved flag words with registered depth counter and full/empty decode.
// Push/pop arrive already qualified; the counter never wraps.
module flag_lifo
   import flagreg_pkg::*;
#(
   parameter int NFLAGS = NFLAGS_DEF,
   parameter int DEPTH  = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic [NFLAGS-1:0]          din,
   output logic [NFLAGS-1:0]          top,
   output logic [$clog2(DEPTH+1)-1:0] depth,
   output logic                       full,
   output logic                       empty
);

   localparam int DW = $clog2(DEPTH + 1);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [NFLAGS-1:0] mem_r [DEPTH];
   logic [DW-1:0]     depth_r;
   logic              full_r;
   logic              empty_r;
   logic [DW-1:0]     depth_inc_s;
   logic [DW-1:0]     depth_dec_s;
   logic [AW-1:0]     wr_idx_s;
   logic [AW-1:0]     rd_idx_s;

   // Neighbouring counter values and the write/read slots they address.
   always_comb begin
      depth_inc_s = depth_r + DW'(1);
      depth_dec_s = depth_r - DW'(1);
      wr_idx_s    = depth_r[AW-1:0];
      rd_idx_s    = depth_dec_s[AW-1:0];
   end

   // Depth counter with full/empty flags registered alongside it.
   always_ff @(posedge clk) begin
      if (rst) begin
         depth_r <= '0;
         full_r  <= 1'b0;
         empty_r <= 1'b1;
      end else if (push) begin
         depth_r <= depth_inc_s;
         full_r  <= (depth_inc_s == DW'(DEPTH));
         empty_r <= 1'b0;
      end else if (pop) begin
         depth_r <= depth_dec_s;
         full_r  <= 1'b0;
         empty_r <= (depth_dec_s == DW'(0));
      end else begin
         depth_r <= depth_r;
         full_r  <= full_r;
         empty_r <= empty_r;
      end
   end

   // Saved words need no reset; a discarded slot is never read before it is rewritten.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_r[wr_idx_s] <= din;
      end
   end

   assign top   = mem_r[rd_idx_s];
   assign depth = depth_r;
   assign full  = full_r;
   assign empty = empty_r;

endmodule

// File: rtl/flagstack_reg.sv
// Live condition flags with masked write and a save/restore stack for nested interrupts.
// Optional sticky overflow/underflow outputs when FLAGSTACK_ERR_EN is defined.
module flagstack_reg
   import flagreg_pkg::*;
#(
   parameter int NFLAGS      = NFLAGS_DEF,
   parameter int DEPTH       = 4,
   parameter bit CLR_ON_PUSH = 1'b0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cen,
   input  logic                       we,
   input  logic [NFLAGS-1:0]          wmask_i,
   input  logic [NFLAGS-1:0]          flags_i,
   input  logic                       push_i,
   input  logic                       pop_i,
   output logic [NFLAGS-1:0]          flags_o,
   output logic [$clog2(DEPTH+1)-1:0] depth_o,
   output logic                       full_o,
   output logic                       empty_o
`ifdef FLAGSTACK_ERR_EN
   ,
   output logic                       ovf_o,
   output logic                       udf_o
`endif
);

   function automatic logic [NFLAGS-1:0] masked_write(
      input logic [NFLAGS-1:0] old_v,
      input logic [NFLAGS-1:0] new_v,
      input logic [NFLAGS-1:0] mask_v
   );
      return (old_v & ~mask_v) | (new_v & mask_v);
   endfunction

   flag_op_e          op_s;
   logic              push_acc_s;
   logic              pop_acc_s;
   logic              full_s;
   logic              empty_s;
   logic [NFLAGS-1:0] top_s;
   logic [NFLAGS-1:0] push_base_s;
   logic [NFLAGS-1:0] flags_nxt_s;
   logic [NFLAGS-1:0] flags_r;

   // Op priority: accepted push, accepted pop, then plain write.
   always_comb begin
      op_s = OP_NONE;
      if (!cen) begin
         op_s = OP_NONE;
      end else if (push_i && !pop_i && !full_s) begin
         op_s = OP_PUSH;
      end else if (pop_i && !push_i && !empty_s) begin
         op_s = OP_POP;
      end else if (we) begin
         op_s = OP_WRITE;
      end else begin
         op_s = OP_NONE;
      end
   end

   assign push_acc_s = (op_s == OP_PUSH);
   assign pop_acc_s  = (op_s == OP_POP);

   // Next live flags; a restore discards any same-cycle write.
   always_comb begin
      push_base_s = CLR_ON_PUSH ? '0 : flags_r;
      flags_nxt_s = flags_r;
      case (op_s)
         OP_PUSH: begin
            if (we) begin
               flags_nxt_s = masked_write(push_base_s, flags_i, wmask_i);
            end else begin
               flags_nxt_s = push_base_s;
            end
         end
         OP_POP:   flags_nxt_s = top_s;
         OP_WRITE: flags_nxt_s = masked_write(flags_r, flags_i, wmask_i);
         OP_NONE:  flags_nxt_s = flags_r;
         default:  flags_nxt_s = flags_r;
      endcase
   end

   // Live flag register.
   always_ff @(posedge clk) begin
      if (rst) begin
         flags_r <= '0;
      end else begin
         flags_r <= flags_nxt_s;
      end
   end

   flag_lifo #(
      .NFLAGS (NFLAGS),
      .DEPTH  (DEPTH)
   ) u_lifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_acc_s),
      .pop   (pop_acc_s),
      .din   (flags_r),
      .top   (top_s),
      .depth (depth_o),
      .full  (full_s),
      .empty (empty_s)
   );

   assign flags_o = flags_r;
   assign full_o  = full_s;
   assign empty_o = empty_s;

`ifdef FLAGSTACK_ERR_EN
   logic ovf_r;
   logic udf_r;

   // Sticky misuse flags, cleared only by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_r <= 1'b0;
         udf_r <= 1'b0;
      end else begin
         if (cen && push_i && !pop_i && full_s) begin
            ovf_r <= 1'b1;
         end
         if (cen && pop_i && !push_i && empty_s) begin
            udf_r <= 1'b1;
         end
      end
   end

   assign ovf_o = ovf_r;
   assign udf_o = udf_r;
`endif

endmodule

// File: tb/tb_flagstack_reg.sv
// Directed table-driven bench for flagstack_reg, default and clear-on-push variants.
module tb_flagstack_reg;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       cen = 1'b0;
   logic       we = 1'b0;
   logic [1:0] wmask = 2'b00;
   logic [1:0] fin = 2'b00;
   logic       push = 1'b0;
   logic       pop = 1'b0;

   logic [1:0] flags_a, flags_b;
   logic [2:0] depth_a, depth_b;
   logic       full_a, full_b, empty_a, empty_b;
`ifdef FLAGSTACK_ERR_EN
   logic       ovf_a, udf_a, ovf_b, udf_b;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   flagstack_reg #(.NFLAGS(2), .DEPTH(4), .CLR_ON_PUSH(1'b0)) u_dut (
      .clk(clk), .rst(rst), .cen(cen), .we(we), .wmask_i(wmask), .flags_i(fin),
      .push_i(push), .pop_i(pop), .flags_o(flags_a), .depth_o(depth_a),
      .full_o(full_a), .empty_o(empty_a)
`ifdef FLAGSTACK_ERR_EN
      , .ovf_o(ovf_a), .udf_o(udf_a)
`endif
   );

   flagstack_reg #(.NFLAGS(2), .DEPTH(4), .CLR_ON_PUSH(1'b1)) u_clr (
      .clk(clk), .rst(rst), .cen(cen), .we(we), .wmask_i(wmask), .flags_i(fin),
      .push_i(push), .pop_i(pop), .flags_o(flags_b), .depth_o(depth_b),
      .full_o(full_b), .empty_o(empty_b)
`ifdef FLAGSTACK_ERR_EN
      , .ovf_o(ovf_b), .udf_o(udf_b)
`endif
   );

   typedef struct {
      logic       r, c, w;
      logic [1:0] m, f;
      logic       pu, po;
      logic [1:0] ef;
      logic [1:0] efc;
      logic [2:0] ed;
      logic       eovf, eudf;
   } vec_t;

   localparam int NV = 33;
   vec_t vecs [NV];

   function automatic vec_t mk(input logic r, c, w, input logic [1:0] m, f,
                               input logic pu, po, input logic [1:0] ef, efc,
                               input logic [2:0] ed, input logic eovf, eudf);
      vec_t v;
      v.r = r; v.c = c; v.w = w; v.m = m; v.f = f; v.pu = pu; v.po = po;
      v.ef = ef; v.efc = efc; v.ed = ed; v.eovf = eovf; v.eudf = eudf;
      return v;
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial begin
      //                r     c     w     m      f      pu    po    ef     efc    ed    ovf   udf
      vecs[0]  = mk(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 3'd0, 1'b0, 1'b0);
      vecs[1]  = mk(1'b0, 1'b1, 1'b1, 2'b01, 2'b11, 1'b0, 1'b0, 2'b01, 2'b01, 3'd0, 1'b0, 1'b0);
      vecs[2]  = mk(1'b0, 1'b0, 1'b1, 2'b11, 2'b10, 1'b0, 1'b0, 2'b01, 2'b01, 3'd0, 1'b0, 1'b0);
      vecs[3]  = mk(1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 2'b01, 2'b00, 3'd1, 1'b0, 1'b0);
      vecs[4]  = mk(1'b0, 1'b1, 1'b1, 2'b11, 2'b10, 1'b0, 1'b0, 2'b10, 2'b10, 3'd1, 1'b0, 1'b0);
      vecs[5]  = mk(1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 2'b10, 2'b00, 3'd2, 1'b0, 1'b0);
      vecs[6]  = mk(1'b0, 1'b1, 1'b1, 2'b11, 2'b11, 1'b0, 1'b0, 2'b11, 2'b11, 3'd2, 1'b0, 1'b0);
      vecs[7]  = mk(1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 2'b10, 2'b10, 3'd1, 1'b0, 1'b0);
      vecs[8]  = mk(1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 2'b01, 2'b01, 3'd0, 1'b0, 1'b0);
      vecs[9]  = mk(1'b0, 1'b1, 1'b1, 2'b11, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 3'd0, 1'b0, 1'b0);
      vecs[10] = mk(1'b0, 1'b1, 1'b1, 2'b11, 2'b01, 1'b1, 1'b0, 2'b01, 2'b01, 3'd1, 1'b0, 1'b0);
      vecs[11] = mk(1'b0, 1'b1, 1'b1, 2'b11, 2'b10, 1'b1, 1'b0, 2'b10, 2'b10, 3'd2, 1'b0, 1'b0);
      vecs[12] = mk(1'b0, 1'b1, 1'b1, 2'b11, 2'b11, 1'b1, 1'b0, 2'b11, 2'b11, 3'd3, 1'b0, 1'b0);
      vecs[13] = mk(1'b0, 1'b1, 1'b1, 2'b11, 2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 3'd4, 1'b0, 1'b0);
      vecs[14] = mk(1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 3'd4, 1'b1, 1'b0);
      vecs[15] = mk(1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 2'b11, 2'b11, 3'd3, 1'b1, 1'b0);
      vecs[16] = mk(1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 2'b10, 2'b10, 3'd2, 1'b1, 1'b0);
      vecs[17] = mk(1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 2'b01, 2'b01, 3'd1, 1'b1, 1'b0);
      vecs[18] = mk(1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 2'b00, 2'b00, 3'd0, 1'b1, 1'b0);
      vecs[19] = mk(1'b0, 1'b1, 1'b1, 2'b11, 2'b11, 1'b0, 1'b1, 2'b11, 2'b11, 3'd0, 1'b1, 1'b1);
      vecs[20] = mk(1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 2'b11, 2'b00, 3'd1, 1'b1, 1'b1);
      vecs[21] = mk(1'b0, 1'b1, 1'b1, 2'b11, 2'b00, 1'b0, 1'b1, 2'b11, 2'b11, 3'd0, 1'b1, 1'b1);
      vecs[22] = mk(1'b0, 1'b1, 1'b1, 2'b11, 2'b10, 1'b0, 1'b0, 2'b10, 2'b10, 3'd0, 1'b1, 1'b1);
      vecs[23] = mk(1'b0, 1'b1, 1'b1, 2'b11, 2'b01, 1'b1, 1'b0, 2'b01, 2'b01, 3'd1, 1'b1, 1'b1);
      vecs[24] = mk(1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 2'b10, 2'b10, 3'd0, 1'b1, 1'b1);
      vecs[25] = mk(1'b0, 1'b1, 1'b1, 2'b11, 2'b10, 1'b0, 1'b0, 2'b10, 2'b10, 3'd0, 1'b1, 1'b1);
      vecs[26] = mk(1'b0, 1'b1, 1'b1, 2'b01, 2'b01, 1'b1, 1'b0, 2'b11, 2'b01, 3'd1, 1'b1, 1'b1);
      vecs[27] = mk(1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 2'b11, 2'b00, 3'd2, 1'b1, 1'b1);
      vecs[28] = mk(1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 2'b11, 2'b00, 3'd2, 1'b1, 1'b1);
      vecs[29] = mk(1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 2'b11, 2'b01, 3'd1, 1'b1, 1'b1);
      vecs[30] = mk(1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 2'b11, 2'b00, 3'd2, 1'b1, 1'b1);
      vecs[31] = mk(1'b1, 1'b1, 1'b1, 2'b11, 2'b11, 1'b1, 1'b0, 2'b00, 2'b00, 3'd0, 1'b0, 1'b0);
      vecs[32] = mk(1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 2'b00, 2'b00, 3'd0, 1'b0, 1'b1);

      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         rst = vecs[i].r; cen = vecs[i].c; we = vecs[i].w; wmask = vecs[i].m;
         fin = vecs[i].f; push = vecs[i].pu; pop = vecs[i].po;
         @(posedge clk);
         #1;
         chk($sformatf("v%0d flags", i), {6'd0, flags_a}, {6'd0, vecs[i].ef});
         chk($sformatf("v%0d depth", i), {5'd0, depth_a}, {5'd0, vecs[i].ed});
         chk($sformatf("v%0d full", i), {7'd0, full_a}, {7'd0, vecs[i].ed == 3'd4});
         chk($sformatf("v%0d empty", i), {7'd0, empty_a}, {7'd0, vecs[i].ed == 3'd0});
         chk($sformatf("v%0d clr_flags", i), {6'd0, flags_b}, {6'd0, vecs[i].efc});
         chk($sformatf("v%0d clr_depth", i), {5'd0, depth_b}, {5'd0, vecs[i].ed});
`ifdef FLAGSTACK_ERR_EN
         chk($sformatf("v%0d ovf", i), {7'd0, ovf_a}, {7'd0, vecs[i].eovf});
         chk($sformatf("v%0d udf", i), {7'd0, udf_a}, {7'd0, vecs[i].eudf});
`endif
      end

      // Inputs must not reach flags_o before the next edge.
      @(negedge clk);
      rst = 1'b0; cen = 1'b1; we = 1'b1; wmask = 2'b11; fin = 2'b11; push = 1'b0; pop = 1'b0;
      #1;
      chk("no_comb_path flags", {6'd0, flags_a}, 8'h00);
      @(posedge clk);
      #1;
      chk("write_after flags", {6'd0, flags_a}, 8'h03);

      // Gated push and pop are dropped, not deferred.
      @(negedge clk);
      cen = 1'b0; we = 1'b0; push = 1'b1;
      @(posedge clk);
      #1;
      chk("gated_push depth", {5'd0, depth_a}, 8'h00);
      @(negedge clk);
      cen = 1'b1; push = 1'b0;
      @(posedge clk);
      #1;
      chk("deferred_push depth", {5'd0, depth_a}, 8'h00);
      chk("deferred_push empty", {7'd0, empty_a}, 8'h01);
      chk("hold flags", {6'd0, flags_a}, 8'h03);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
